// File: rtl/kvs_arb_pkg.sv
// Shared defaults and types for the KVS host-port arbiter.
package kvs_arb_pkg;

   localparam int unsigned NUM_PORTS_DEF  = 6;
   localparam int unsigned DATA_WIDTH_DEF = 512;
   localparam int unsigned ID_WIDTH       = $clog2(NUM_PORTS_DEF);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/kvs_port_arbiter_rr_picker.sv
// Rotating first-eligible search: returns the first set bit of eligible_i
// starting at ptr_i and wrapping modulo N.
module rr_picker #(
   parameter int unsigned N   = 6,
   parameter int unsigned IDW = 3
) (
   input  logic [N-1:0]   eligible_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [IDW-1:0] idx_o,
   output logic           any_o
);

   // Walk offsets from farthest to nearest so the nearest match wins.
   always_comb begin
      idx_o = '0;
      any_o = |eligible_i;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         for (int j = 0; j < int'(N); j++) begin
            if (eligible_i[j] && (j == ((int'(ptr_i) + k) % int'(N)))) begin
               idx_o = IDW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/kvs_port_arbiter.sv
// Shares one KVS engine between NUM_PORTS host request streams with
// round-robin bursts, per-port outstanding limits and response demux.
module kvs_port_arbiter
   import kvs_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = NUM_PORTS_DEF,
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned MAX_BURST       = 8,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned IDW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [NUM_PORTS-1:0]            s_valid,
   output logic [NUM_PORTS-1:0]            s_ready,
   input  logic [NUM_PORTS-1:0]            s_last,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic [IDW-1:0]                  m_id,
   input  logic                            r_valid,
   output logic                            r_ready,
   input  logic [DATA_WIDTH-1:0]           r_data,
   input  logic [IDW-1:0]                  r_id,
   output logic [NUM_PORTS-1:0]            d_valid,
   input  logic [NUM_PORTS-1:0]            d_ready,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] d_data,
   output logic                            busy,
   output logic                            err_id
);

   localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned BCW = $clog2(MAX_BURST + 1);

   arb_state_e           state_q;
   logic [IDW-1:0]       g_q;
   logic [IDW-1:0]       p_q;
   logic [BCW-1:0]       bc_q;
   logic [OCW-1:0]       oc_q [NUM_PORTS];
   logic [OCW-1:0]       oc_d [NUM_PORTS];
   logic                 err_q;
   logic                 err_d;

   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] inc;
   logic [NUM_PORTS-1:0] deliver;
   logic [IDW-1:0]       pick_idx;
   logic                 pick_any;
   logic                 in_burst;
   logic                 acc;
   logic                 burst_end;
   logic                 rid_ok;
   logic [IDW-1:0]       next_ptr;

   rr_picker #(
      .N   (NUM_PORTS),
      .IDW (IDW)
   ) u_picker (
      .eligible_i (elig),
      .ptr_i      (p_q),
      .idx_o      (pick_idx),
      .any_o      (pick_any)
   );

   // Request path: zero-latency pass-through of the granted port.
   always_comb begin
      in_burst = (state_q == ST_BURST);
      m_valid  = in_burst & s_valid[g_q];
      m_data   = s_data[g_q*DATA_WIDTH +: DATA_WIDTH];
      m_id     = g_q;
      s_ready  = '0;
      if (in_burst) begin
         s_ready[g_q] = m_ready;
      end
      acc       = m_valid & m_ready;
      burst_end = acc & (s_last[g_q] |
                         (bc_q == BCW'(MAX_BURST - 1)) |
                         (oc_q[g_q] == OCW'(MAX_OUTSTANDING - 1)));
      next_ptr  = (g_q == IDW'(NUM_PORTS - 1)) ? '0 : g_q + 1'b1;
      inc       = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         elig[i] = s_valid[i] & (oc_q[i] < OCW'(MAX_OUTSTANDING));
         inc[i]  = acc & (g_q == IDW'(i));
      end
   end

   // Response demux; an out-of-range id is swallowed so the engine never stalls.
   always_comb begin
      rid_ok  = ({1'b0, r_id} < (IDW + 1)'(NUM_PORTS));
      r_ready = rid_ok ? d_ready[r_id] : 1'b1;
      d_data  = {NUM_PORTS{r_data}};
      d_valid = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         d_valid[i] = r_valid & rid_ok & (r_id == IDW'(i));
      end
      deliver = d_valid & d_ready;
   end

   // Outstanding bookkeeping; simultaneous accept and delivery cancel out.
   always_comb begin
      err_d = err_q | (r_valid & ~rid_ok);
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         oc_d[i] = oc_q[i];
         if (deliver[i] && (oc_q[i] == '0)) begin
            err_d = 1'b1;
         end
         if (inc[i] && !deliver[i] && (oc_q[i] != OCW'(MAX_OUTSTANDING))) begin
            oc_d[i] = oc_q[i] + 1'b1;
         end else if (deliver[i] && !inc[i] && (oc_q[i] != '0)) begin
            oc_d[i] = oc_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         p_q     <= '0;
         bc_q    <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            oc_q[i] <= '0;
         end
      end else begin
         err_q <= err_d;
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            oc_q[i] <= oc_d[i];
         end
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q <= ST_BURST;
                  g_q     <= pick_idx;
                  bc_q    <= '0;
               end
            end
            ST_BURST: begin
               if (acc) begin
                  bc_q <= bc_q + 1'b1;
                  if (burst_end) begin
                     state_q <= ST_IDLE;
                     p_q     <= next_ptr;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy   = (state_q == ST_BURST);
   assign err_id = err_q;

endmodule

// File: tb/tb_kvs_port_arbiter.sv
// Directed and randomized checks of kvs_port_arbiter against a cycle-level
// behavioural model of the arbitration and outstanding-count rules.
module tb_kvs_port_arbiter;

   localparam int N    = 6;
   localparam int DW   = 32;
   localparam int MAXB = 8;
   localparam int MAXO = 16;
   localparam int IDW  = 3;

   logic              aclk;
   logic              areset;
   logic [N-1:0]      s_valid, s_ready, s_last;
   logic [N*DW-1:0]   s_data;
   logic              m_valid, m_ready;
   logic [DW-1:0]     m_data;
   logic [IDW-1:0]    m_id;
   logic              r_valid, r_ready;
   logic [DW-1:0]     r_data;
   logic [IDW-1:0]    r_id;
   logic [N-1:0]      d_valid, d_ready;
   logic [N*DW-1:0]   d_data;
   logic              busy, err_id;

   kvs_port_arbiter #(
      .NUM_PORTS       (N),
      .DATA_WIDTH      (DW),
      .MAX_BURST       (MAXB),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .aclk    (aclk),    .areset  (areset),
      .s_valid (s_valid), .s_ready (s_ready), .s_last (s_last), .s_data (s_data),
      .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_id   (m_id),
      .r_valid (r_valid), .r_ready (r_ready), .r_data (r_data), .r_id   (r_id),
      .d_valid (d_valid), .d_ready (d_ready), .d_data (d_data),
      .busy    (busy),    .err_id  (err_id)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state
   bit mb;
   int mg, mp, mbc;
   int moc [N];
   bit merr;
   int last_acc;

   // Packet sources
   int rem [N];
   int plen [N];
   bit autor [N];
   bit rndlen [N];
   bit en [N];
   logic [DW-1:0] dat [N];

   // DUT observations
   int dut_grants [$];
   int dut_blen [$];
   int dut_acc [8];
   int beat_cnt;
   bit pbusy;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return -1;
   endfunction

   task automatic model_reset();
      mb = 0; mg = 0; mp = 0; mbc = 0; merr = 0;
      for (int i = 0; i < N; i++) moc[i] = 0;
   endtask

   task automatic clear_obs();
      dut_grants.delete();
      dut_blen.delete();
      for (int i = 0; i < 8; i++) dut_acc[i] = 0;
      beat_cnt = 0;
      pbusy = 0;
   endtask

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         s_valid[i] = en[i] && (rem[i] > 0);
         s_last[i]  = (rem[i] == 1);
         s_data[i*DW +: DW] = dat[i];
      end
   endtask

   task automatic start_src(input int i, input int len, input bit auto_reload);
      rem[i] = len; plen[i] = len; autor[i] = auto_reload; rndlen[i] = 0;
      en[i] = 1; dat[i] = $urandom;
   endtask

   task automatic stop_all();
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; en[i] = 0; autor[i] = 0; rndlen[i] = 0;
      end
      m_ready = 0; r_valid = 0; r_id = '0; d_ready = '0;
   endtask

   task automatic check_outputs();
      logic [N-1:0] e_sready, e_dvalid;
      logic e_mvalid, e_rready;
      bit rid_ok;
      if (areset) model_reset();
      rid_ok   = int'(r_id) < N;
      e_mvalid = mb && s_valid[mg];
      e_sready = '0;
      if (mb && m_ready) e_sready[mg] = 1'b1;
      e_rready = rid_ok ? d_ready[r_id] : 1'b1;
      e_dvalid = '0;
      if (r_valid && rid_ok) e_dvalid[r_id] = 1'b1;
      chk("m_valid", 256'(m_valid), 256'(e_mvalid));
      chk("s_ready", 256'(s_ready), 256'(e_sready));
      chk("busy",    256'(busy),    256'(mb));
      chk("err_id",  256'(err_id),  256'(merr));
      chk("r_ready", 256'(r_ready), 256'(e_rready));
      chk("d_valid", 256'(d_valid), 256'(e_dvalid));
      chk("d_data",  256'(d_data),  256'({N{r_data}}));
      if (mb) chk("m_id", 256'(m_id), 256'(mg));
      if (e_mvalid) chk("m_data", 256'(m_data), 256'(s_data[mg*DW +: DW]));
   endtask

   task automatic observe();
      if (busy && !pbusy) begin
         dut_grants.push_back(int'(m_id));
         beat_cnt = 0;
      end
      if (!busy && pbusy) dut_blen.push_back(beat_cnt);
      if (m_valid && m_ready) begin
         dut_acc[m_id]++;
         beat_cnt++;
      end
      pbusy = busy;
   endtask

   task automatic model_step();
      bit acc, fin, found, inc, dec;
      int nocs [N];
      last_acc = -1;
      if (areset) begin
         model_reset();
         return;
      end
      acc = mb && s_valid[mg] && m_ready;
      if (acc) last_acc = mg;
      if (r_valid && int'(r_id) >= N) merr = 1;
      for (int i = 0; i < N; i++) begin
         inc = acc && (mg == i);
         dec = r_valid && (int'(r_id) == i) && d_ready[i];
         if (dec && moc[i] == 0) merr = 1;
         nocs[i] = moc[i];
         if (inc && !dec) nocs[i] = moc[i] + 1;
         else if (dec && !inc && moc[i] > 0) nocs[i] = moc[i] - 1;
      end
      if (!mb) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (mp + k) % N;
            if (!found && s_valid[j] && moc[j] < MAXO) begin
               found = 1; mb = 1; mg = j; mbc = 0;
            end
         end
      end else if (acc) begin
         fin = s_last[mg] || (mbc + 1 == MAXB) || (moc[mg] + 1 == MAXO);
         mbc++;
         if (fin) begin
            mb = 0;
            mp = (mg + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) moc[i] = nocs[i];
   endtask

   task automatic src_step();
      int i;
      if (last_acc < 0) return;
      i = last_acc;
      rem[i]--;
      dat[i] = $urandom;
      if (rem[i] == 0 && autor[i])
         rem[i] = rndlen[i] ? int'($urandom_range(1, 12)) : plen[i];
   endtask

   task automatic tick();
      drive_src();
      @(negedge aclk);
      check_outputs();
      observe();
      @(posedge aclk);
      model_step();
      src_step();
      #1;
      drive_src();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      tick();
      tick();
      areset = 1'b0;
      clear_obs();
   endtask

   initial begin
      int guard;
      int exp036 [3];
      int exp037g [5];
      int exp037l [5];
      exp036  = '{0, 2, 5};
      exp037g = '{1, 4, 1, 4, 1};
      exp037l = '{8, 1, 8, 1, 4};
      areset = 1'b1;
      s_valid = '0; s_last = '0; s_data = '0;
      r_data = '0;
      stop_all();
      for (int i = 0; i < N; i++) dat[i] = '0;
      model_reset();
      clear_obs();
      repeat (3) tick();
      areset = 1'b0;
      tick();
      chk("reset_err_id", 256'(err_id), 256'(0));

      // Three ports, continuous 3-beat packets: strict rotation 0,2,5.
      start_src(0, 3, 1); start_src(2, 3, 1); start_src(5, 3, 1);
      m_ready = 1;
      clear_obs();
      repeat (30) tick();
      for (int k = 0; k < 6; k++) begin
         chk("rr_grant", 256'(qget(dut_grants, k)), 256'(exp036[k % 3]));
         chk("rr_blen",  256'(qget(dut_blen, k)),   256'(3));
      end

      // Long packet on port 1 is split at MAX_BURST; port 4 slots in between.
      stop_all();
      do_reset();
      start_src(1, 20, 0); start_src(4, 1, 1);
      m_ready = 1; d_ready = '1;
      repeat (40) begin
         r_data = $urandom;
         if (moc[1] > 0) begin r_valid = 1; r_id = 3'd1; end
         else if (moc[4] > 0) begin r_valid = 1; r_id = 3'd4; end
         else r_valid = 0;
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         chk("split_grant", 256'(qget(dut_grants, k)), 256'(exp037g[k]));
         chk("split_blen",  256'(qget(dut_blen, k)),   256'(exp037l[k]));
      end

      // Outstanding limit: port 3 stalls after 16, one response frees a slot.
      stop_all();
      do_reset();
      start_src(3, 1, 1);
      m_ready = 1;
      repeat (50) tick();
      chk("oc_limit_count", 256'(dut_acc[3]), 256'(16));
      chk("oc_limit_idle",  256'(busy), 256'(0));
      r_valid = 1; r_id = 3'd3; d_ready = 6'b001000; r_data = $urandom;
      tick();
      r_valid = 0;
      repeat (6) tick();
      chk("oc_refill", 256'(dut_acc[3]), 256'(17));
      repeat (10) tick();
      chk("oc_refill_stall", 256'(dut_acc[3]), 256'(17));

      // Accept and response for the same port in the same cycle.
      stop_all();
      do_reset();
      start_src(2, 1, 1);
      m_ready = 1; d_ready = 6'b000100;
      guard = 0;
      while (dut_acc[2] < 5 && guard < 40) begin tick(); guard++; end
      chk("same_cyc_pre", 256'(dut_acc[2]), 256'(5));
      guard = 0;
      while (dut_acc[2] < 6 && guard < 10) begin
         r_valid = mb; r_id = 3'd2; r_data = $urandom;
         tick();
         guard++;
      end
      r_valid = 0;
      chk("same_cyc_hit", 256'(dut_acc[2]), 256'(6));
      repeat (40) tick();
      chk("same_cyc_total", 256'(dut_acc[2]), 256'(17));

      // Illegal response id: swallowed, error sticks until reset.
      chk("err_before", 256'(err_id), 256'(0));
      r_valid = 1; r_id = 3'd7; d_ready = '0; r_data = $urandom;
      tick();
      r_valid = 0;
      repeat (5) tick();
      chk("err_sticky", 256'(err_id), 256'(1));

      // Reset in the middle of a burst with the pointer parked at 3.
      stop_all();
      do_reset();
      chk("err_cleared", 256'(err_id), 256'(0));
      m_ready = 1;
      start_src(2, 1, 0);
      repeat (4) tick();
      start_src(0, 4, 0);
      guard = 0;
      while (dut_acc[0] < 1 && guard < 10) begin tick(); guard++; end
      start_src(3, 2, 0);
      drive_src();
      #2;
      areset = 1'b1;
      #1;
      chk("abort_m_valid", 256'(m_valid), 256'(0));
      chk("abort_busy",    256'(busy),    256'(0));
      chk("abort_s_ready", 256'(s_ready), 256'(0));
      model_reset();
      tick();
      areset = 1'b0;
      clear_obs();
      repeat (12) tick();
      chk("abort_regrant", 256'(qget(dut_grants, 0)), 256'(0));
      chk("abort_next",    256'(qget(dut_grants, 1)), 256'(3));

      // Randomized traffic against the model.
      stop_all();
      do_reset();
      for (int i = 0; i < N; i++) begin
         start_src(i, int'($urandom_range(1, 12)), 1);
         rndlen[i] = 1;
      end
      repeat (600) begin
         for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 3) != 0);
         r_valid = ($urandom_range(0, 4) < 3);
         r_id    = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                : 3'($urandom_range(0, N - 1));
         r_data  = $urandom;
         d_ready = 6'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
